// File: rtl/sample_points_stream.sv
// sample_points_stream: streaming ray sampler. Latches one ray descriptor per
// transaction and emits N_SAMPLES points o + d*z[k] in index order, one point
// per beat, in signed fixed point with saturating arithmetic.
module sample_points_stream #(
    parameter int INT_BITS   = 12,
    parameter int FRAC_BITS  = 4,
    parameter int TOTAL_BITS = 16,
    parameter int N_SAMPLES  = 16,
    parameter int LOG2_N     = 4,
    parameter int SPAN_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic [TOTAL_BITS-1:0]   in_depth,
    input  logic [TOTAL_BITS-1:0]   in_near,
    input  logic [TOTAL_BITS-1:0]   in_far,
    input  logic [3*TOTAL_BITS-1:0] in_rays_o,
    input  logic [3*TOTAL_BITS-1:0] in_rays_d,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3*TOTAL_BITS-1:0] out_pt,
    output logic [TOTAL_BITS-1:0]   out_z,
    output logic [LOG2_N-1:0]       out_idx,
    output logic                    out_last,
    output logic                    out_sat,
    output logic                    out_hole
);

    localparam int W          = INT_BITS + FRAC_BITS;
    localparam int STEP_SHIFT = SPAN_SHIFT + LOG2_N - 1;

    localparam logic [LOG2_N-1:0]          LAST_IDX    = LOG2_N'(N_SAMPLES - 1);
    localparam logic [LOG2_N-1:0]          ZERO_IDX    = {LOG2_N{1'b0}};
    localparam logic [W-1:0]               SAT_MAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]               SAT_MIN     = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [2*W-1:0]      SAT_MAX_EXT = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0]      SAT_MIN_EXT = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [W-1:0]        ZERO_W      = {W{1'b0}};
    localparam logic signed [W:0]          ZERO_W1     = {(W+1){1'b0}};
    localparam logic signed [W+1:0]        ZERO_W2     = {(W+2){1'b0}};
    localparam logic [3*W-1:0]             ZERO_PT     = {(3*W){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    // Clamp a wide signed value into W bits; result is {saturated, value}.
    function automatic logic [W:0] sat_w(input logic signed [2*W-1:0] v);
        logic [W:0] r;
        if (v > SAT_MAX_EXT) begin
            r = {1'b1, SAT_MAX};
        end else if (v < SAT_MIN_EXT) begin
            r = {1'b1, SAT_MIN};
        end else begin
            r = {1'b0, v[W-1:0]};
        end
        return r;
    endfunction

    // Fixed-point multiply: full product rescaled by FRAC_BITS, then clamped.
    function automatic logic [W:0] fx_mul(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b);
        logic signed [2*W-1:0] ae;
        logic signed [2*W-1:0] be;
        logic signed [2*W-1:0] p;
        ae = a;
        be = b;
        p  = (ae * be) >>> FRAC_BITS;
        return sat_w(p);
    endfunction

    // Fixed-point add with clamp.
    function automatic logic [W:0] fx_add(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b);
        logic signed [2*W-1:0] ae;
        logic signed [2*W-1:0] be;
        ae = a;
        be = b;
        return sat_w(ae + be);
    endfunction

    state_t state_r;
    state_t state_s;
    logic   accept_s;
    logic   load_s;
    logic   done_s;
    logic   in_ready_r;

    // Latched ray descriptor
    logic                mode_r;
    logic signed [W-1:0] depth_r;
    logic signed [W-1:0] near_r;
    logic signed [W-1:0] far_r;
    logic [3*W-1:0]      o_r;
    logic [3*W-1:0]      d_r;

    // Sampling schedule derived from the ray
    logic signed [W-1:0] span_s;
    logic signed [W:0]   diff_s;
    logic signed [W-1:0] z0_s;
    logic signed [W-1:0] step_s;
    logic                hole_s;

    logic signed [W+1:0] z_acc_r;
    logic signed [W-1:0] step_r;
    logic [LOG2_N-1:0]   k_r;
    logic                hole_r;

    // Point datapath
    logic signed [2*W-1:0] z_ext_s;
    logic [W:0]            z_pack_s;
    logic [W:0]            mul_s [3];
    logic [W:0]            add_s [3];
    logic [3*W-1:0]        pt_s;
    logic                  sat_s;

    // Output registers
    logic              out_valid_r;
    logic [3*W-1:0]    out_pt_r;
    logic [W-1:0]      out_z_r;
    logic [LOG2_N-1:0] out_idx_r;
    logic              out_last_r;
    logic              out_sat_r;
    logic              out_hole_r;

    assign accept_s = (state_r == ST_IDLE) && in_valid && in_ready_r;
    assign load_s   = (state_r == ST_EMIT) && (!out_valid_r || (out_ready && !out_last_r));
    assign done_s   = (state_r == ST_EMIT) && out_valid_r && out_ready && out_last_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: one ray at a time, back to IDLE after the last beat fires.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_EMIT;
            end
            ST_EMIT: begin
                if (done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Registered in_ready: low through reset, high whenever the next state is IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0;
        end else begin
            in_ready_r <= (state_s == ST_IDLE);
        end
    end

    // Capture the ray descriptor on the input handshake only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r  <= 1'b0;
            depth_r <= ZERO_W;
            near_r  <= ZERO_W;
            far_r   <= ZERO_W;
            o_r     <= ZERO_PT;
            d_r     <= ZERO_PT;
        end else if (accept_s) begin
            mode_r  <= in_mode;
            depth_r <= in_depth;
            near_r  <= in_near;
            far_r   <= in_far;
            o_r     <= in_rays_o;
            d_r     <= in_rays_d;
        end
    end

    // Start depth, step and hole flag for surface (bracket) or uniform (near..far) sampling.
    always_comb begin
        span_s = depth_r >>> SPAN_SHIFT;
        diff_s = {far_r[W-1], far_r} - {near_r[W-1], near_r};
        z0_s   = ZERO_W;
        step_s = ZERO_W;
        hole_s = 1'b0;
        if (mode_r) begin
            if (depth_r > ZERO_W) begin
                z0_s   = depth_r - span_s;
                step_s = depth_r >>> STEP_SHIFT;
                hole_s = 1'b0;
            end else begin
                z0_s   = ZERO_W;
                step_s = ZERO_W;
                hole_s = 1'b1;
            end
        end else begin
            z0_s = near_r;
            if (diff_s > ZERO_W1) begin
                step_s = W'(diff_s >>> LOG2_N);
                hole_s = 1'b0;
            end else begin
                step_s = ZERO_W;
                hole_s = 1'b1;
            end
        end
    end

    // Sample schedule: load in SETUP, advance depth and index with each loaded point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_acc_r <= ZERO_W2;
            step_r  <= ZERO_W;
            k_r     <= ZERO_IDX;
            hole_r  <= 1'b0;
        end else if (state_r == ST_SETUP) begin
            z_acc_r <= {{2{z0_s[W-1]}}, z0_s};
            step_r  <= step_s;
            k_r     <= ZERO_IDX;
            hole_r  <= hole_s;
        end else if (load_s) begin
            z_acc_r <= z_acc_r + {{2{step_r[W-1]}}, step_r};
            k_r     <= k_r + {{(LOG2_N-1){1'b0}}, 1'b1};
        end
    end

    // Point for the current sample: z clamped to W, then o + d*z per axis.
    always_comb begin
        z_ext_s  = z_acc_r;
        z_pack_s = sat_w(z_ext_s);
        pt_s     = ZERO_PT;
        sat_s    = z_pack_s[W];
        for (int i = 0; i < 3; i++) begin
            mul_s[i] = fx_mul(d_r[i*W +: W], z_pack_s[W-1:0]);
            add_s[i] = fx_add(o_r[i*W +: W], mul_s[i][W-1:0]);
            pt_s[i*W +: W] = add_s[i][W-1:0];
            sat_s = sat_s | mul_s[i][W] | add_s[i][W];
        end
    end

    // Output beat registers: hold under backpressure, drop valid after the last beat fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_pt_r    <= ZERO_PT;
            out_z_r     <= ZERO_W;
            out_idx_r   <= ZERO_IDX;
            out_last_r  <= 1'b0;
            out_sat_r   <= 1'b0;
            out_hole_r  <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_pt_r    <= pt_s;
            out_z_r     <= z_pack_s[W-1:0];
            out_idx_r   <= k_r;
            out_last_r  <= (k_r == LAST_IDX);
            out_sat_r   <= sat_s;
            out_hole_r  <= hole_r;
        end else if (done_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_pt    = out_pt_r;
    assign out_z     = out_z_r;
    assign out_idx   = out_idx_r;
    assign out_last  = out_last_r;
    assign out_sat   = out_sat_r;
    assign out_hole  = out_hole_r;

endmodule
